inport_arbiter: RTL and testbench
=================================

# inport_arbiter

Multi-channel front end that merges several external sample streams onto the single internal data path of a coprocessor cell. Each channel has a one-entry holding register. A round-robin scheduler forwards at most one held word per cycle, sign-extended to the internal width and tagged with its channel number. The block sits between the external sensor/host interfaces and the cell array, where a single-channel input register would otherwise be used.

## Interface
- NUM_CH, 4, number of input channels (2..16)
- IN_MSB, 23, MSB of each external sample
- MSB, 31, internal MSB; must satisfy MSB >= IN_MSB, otherwise elaboration fails
- CH_W, $clog2(NUM_CH), width of the channel tag (derived, do not override)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- in_data  input  NUM_CH*(IN_MSB+1)  flattened samples; channel k occupies bits [k*(IN_MSB+1)+IN_MSB : k*(IN_MSB+1)]
- in_data_en  input  NUM_CH  per-channel sample strobe, one sample per high cycle
- out_ready  input  1  downstream can accept a word this cycle
- internal_data  output  MSB+1  sign-extended forwarded sample (registered)
- internal_data_en  output  1  internal_data valid, single-cycle pulse per word
- internal_ch  output  CH_W  channel index of internal_data
- pending  output  NUM_CH  per-channel hold-register valid bits
- overrun  output  NUM_CH  sticky per-channel overrun flags
- overrun_clr  input  1  clears all overrun bits

## Operation
- **Hold register capture:** when in_data_en[k]=1, the slice for channel k is written into hold[k] and pending[k] is set on that edge.
- **Grant:**
  - Evaluated each cycle when out_ready=1 and |pending.
  - Winner g is the first k with pending[k]=1, scanning upward from rr_ptr with wrap modulo NUM_CH.
- **On a grant, at the next edge:**
  - internal_data = sext(hold[g]);
  - internal_ch = g;
  - internal_data_en = 1;
  - pending[g] is cleared;
  - rr_ptr = (g+1) mod NUM_CH.
- **No grant** (out_ready=0 or no pending): internal_data_en=0. internal_data and internal_ch hold their last values. rr_ptr is unchanged.
- **Sign extension:**
  - If MSB > IN_MSB, the upper MSB-IN_MSB bits replicate bit IN_MSB of the sample.
  - If MSB == IN_MSB, the sample passes through unchanged.
- **Capture while pending, channel k not granted this cycle:**
  - The new sample overwrites hold[k] (newest wins).
  - pending[k] stays 1.
  - The overrun condition for k is raised.
- **Capture on the same cycle channel k is granted:**
  - The old value is forwarded.
  - The new value is captured and pending[k] stays 1.
  - No overrun is raised.
- **Overrun clear:**
  - overrun_clr=1 clears all overrun bits at the edge.
  - A simultaneous overrun event on channel k wins: overrun[k] is set.
- **Reset (rst=0, asynchronous, immediate):** hold, pending, overrun, rr_ptr, internal_data, internal_data_en and internal_ch all go to 0. Reset asserted mid-burst discards every held word.

## Timing
- Latency from in_data_en[k] high (cycle t) to internal_data_en high is 2 cycles (output after edge t+2), when channel k wins arbitration immediately.
- Aggregate throughput is one word per cycle while out_ready=1.
- A pending channel waits at most NUM_CH-1 grants while out_ready stays high.
- out_ready is sampled in the grant cycle. Deasserting it suppresses the next-edge output, with no loss of held data.
- pending and overrun update at the same edge as the capture that causes them.

## Configuration
- INPORT_ARB_OVERRUN_EN, when defined:
  - The overrun sticky flags and the overrun_clr logic are built as described.
- When not defined:
  - overrun is tied to 0 and overrun_clr is ignored.
  - Overwrite-on-pending behaviour (newest wins) is unchanged.

## Test plan
- **Reset:** pulse rst=0 mid-burst with pending=4'b1111 -> all outputs and pending read 0 immediately. The first grant after release comes from ch0.
- **Sign extension** (defaults):
  - ch2 sample 0x800000, out_ready=1 -> 2 cycles later internal_data=0xFF800000, internal_ch=2, internal_data_en high for exactly 1 cycle.
  - ch1 sample 0x7FFFFF -> internal_data=0x007FFFFF.
- **Round robin:**
  - All four strobes in one cycle -> outputs on ch0, ch1, ch2, ch3 in consecutive cycles, leaving rr_ptr=0.
  - Then strobe ch3 and ch1 together -> output order ch1, then ch3.
- **Backpressure:**
  - out_ready=0 while ch0 receives 0x000011, then 0x000022 -> pending[0]=1, overrun[0]=1.
  - Raise out_ready -> a single word 0x00000022 is forwarded on ch0.
  - overrun_clr=1 -> overrun[0]=0.
- **Grant/capture collision:** ch0 holds 0x000005 and a new strobe for 0x000006 arrives in its grant cycle -> 0x5, then 0x6, delivered on ch0, overrun[0] stays 0.
- **Macro off:** rebuild without INPORT_ARB_OVERRUN_EN and repeat the backpressure case -> the forwarded word is still 0x22, and overrun reads 0 throughout.

Source files
------------

// File: rtl/inport_arbiter_if.sv
// inport_arbiter_if: sample-stream / internal-path bundle for inport_arbiter.
// slave modport is the arbiter side, master modport is the source/sink side.
interface inport_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int IN_MSB = 23,
    parameter int MSB    = 31
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*(IN_MSB+1)-1:0] in_data;
    logic [NUM_CH-1:0]            in_data_en;
    logic                         out_ready;
    logic                         overrun_clr;
    logic [MSB:0]                 internal_data;
    logic                         internal_data_en;
    logic [CH_W-1:0]              internal_ch;
    logic [NUM_CH-1:0]            pending;
    logic [NUM_CH-1:0]            overrun;

    modport slave (
        input  in_data, in_data_en, out_ready, overrun_clr,
        output internal_data, internal_data_en, internal_ch, pending, overrun
    );

    modport master (
        output in_data, in_data_en, out_ready, overrun_clr,
        input  internal_data, internal_data_en, internal_ch, pending, overrun
    );
endinterface

// File: rtl/inport_arbiter.sv
// inport_arbiter: per-channel one-entry hold registers merged onto one
// internal path by a round-robin scheduler; forwarded words are sign-extended
// and tagged with their channel.
// Optional feature macro: INPORT_ARB_OVERRUN_EN (sticky overrun flags + clear).

// One channel: hold register, pending bit and optional sticky overrun flag.
module inport_arbiter_lane #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cap_i,
    input  logic [W-1:0] data_i,
    input  logic         gnt_i,
    input  logic         ovr_clr_i,
    output logic [W-1:0] hold_o,
    output logic         pend_o,
    output logic         ovr_o
);
    logic [W-1:0] hold_q;
    logic         pend_q, pend_d;

    // a capture in the grant cycle re-arms pending; the granted old word leaves
    assign pend_d = cap_i | (pend_q & ~gnt_i);

    // hold register: newest sample always wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            pend_q <= 1'b0;
        end else begin
            if (cap_i) hold_q <= data_i;
            pend_q <= pend_d;
        end
    end

    assign hold_o = hold_q;
    assign pend_o = pend_q;

`ifdef INPORT_ARB_OVERRUN_EN
    logic ovr_q, ovr_d, ovr_ev;

    // overwrite of an unforwarded word; a grant in the same cycle drains it first
    assign ovr_ev = cap_i & pend_q & ~gnt_i;
    assign ovr_d  = (ovr_clr_i ? 1'b0 : ovr_q) | ovr_ev;

    // sticky overrun flag, new event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovr_q <= 1'b0;
        else      ovr_q <= ovr_d;
    end

    assign ovr_o = ovr_q;
`else
    logic ovr_clr_unused;
    assign ovr_clr_unused = ovr_clr_i;
    assign ovr_o = 1'b0;
`endif
endmodule

module inport_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IN_MSB = 23,
    parameter int MSB    = 31
) (
    input  logic              clk,
    input  logic              rst,
    inport_arbiter_if.slave   bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int IN_W  = IN_MSB + 1;
    localparam int OUT_W = MSB + 1;

    if (MSB < IN_MSB) begin : g_bad_width
        $error("inport_arbiter: MSB must be >= IN_MSB");
    end

    logic [NUM_CH-1:0][IN_MSB:0] in_slices, hold;
    logic [NUM_CH-1:0]           pend, ovr, gnt_vec;
    logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d, gnt_idx, scan_idx;
    logic                        gnt_vld, any_hit;
    logic signed [IN_MSB:0]      gnt_sample;
    logic [MSB:0]                data_q, data_d;
    logic [CH_W-1:0]             ch_q;
    logic                        data_en_q;

    assign in_slices = bus.in_data;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        inport_arbiter_lane #(.W(IN_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .cap_i     (bus.in_data_en[k]),
            .data_i    (in_slices[k]),
            .gnt_i     (gnt_vec[k]),
            .ovr_clr_i (bus.overrun_clr),
            .hold_o    (hold[k]),
            .pend_o    (pend[k]),
            .ovr_o     (ovr[k])
        );
    end

    // round-robin scan: first pending channel at or after rr_ptr, wrapping
    always_comb begin
        any_hit  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = CH_W'((32'(rr_ptr_q) + 32'(i)) % NUM_CH);
            if (!any_hit && pend[scan_idx]) begin
                any_hit = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign gnt_vld    = any_hit & bus.out_ready;
    assign gnt_vec    = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
    assign gnt_sample = hold[gnt_idx];
    assign data_d     = OUT_W'(gnt_sample);
    assign rr_ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

    // output register and pointer advance; both hold when nothing is granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            ch_q      <= '0;
            data_en_q <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            data_en_q <= gnt_vld;
            if (gnt_vld) begin
                data_q   <= data_d;
                ch_q     <= gnt_idx;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign bus.internal_data    = data_q;
    assign bus.internal_data_en = data_en_q;
    assign bus.internal_ch      = ch_q;
    assign bus.pending          = pend;
    assign bus.overrun          = ovr;
endmodule

// File: tb/tb_inport_arbiter.sv
// tb_inport_arbiter: directed checks of capture, round robin, sign extension,
// backpressure, grant/capture collision and asynchronous reset.
module tb_inport_arbiter;
    localparam int NUM_CH = 4;
    localparam int IN_MSB = 23;
    localparam int MSB    = 31;
    localparam int IW     = IN_MSB + 1;
`ifdef INPORT_ARB_OVERRUN_EN
    localparam logic [31:0] EXP_OVR0 = 32'h1;
`else
    localparam logic [31:0] EXP_OVR0 = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inport_arbiter_if #(.NUM_CH(NUM_CH), .IN_MSB(IN_MSB), .MSB(MSB)) bus ();

    inport_arbiter #(.NUM_CH(NUM_CH), .IN_MSB(IN_MSB), .MSB(MSB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [IN_MSB:0] v);
        bus.in_data[ch*IW +: IW] = v;
        bus.in_data_en[ch]       = 1'b1;
    endtask

    task automatic out(input string tag, input logic [31:0] d, input logic [31:0] ch);
        chk({tag, "_en"},   32'(bus.internal_data_en), 32'h1);
        chk({tag, "_data"}, bus.internal_data, d);
        chk({tag, "_ch"},   32'(bus.internal_ch), ch);
    endtask

    initial begin
        bus.in_data     = '0;
        bus.in_data_en  = '0;
        bus.out_ready   = 1'b0;
        bus.overrun_clr = 1'b0;
        tick; tick;
        chk("rst_en",   32'(bus.internal_data_en), 32'h0);
        chk("rst_data", bus.internal_data, 32'h0);
        chk("rst_ch",   32'(bus.internal_ch), 32'h0);
        chk("rst_pend", 32'(bus.pending), 32'h0);
        chk("rst_ovr",  32'(bus.overrun), 32'h0);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick;

        // all four strobes at once -> ch0..ch3 back to back
        for (int k = 0; k < NUM_CH; k++) put(k, 24'h000100 + 24'(k));
        tick;
        bus.in_data_en = '0;
        chk("rr4_pend", 32'(bus.pending), 32'hF);
        chk("rr4_en0",  32'(bus.internal_data_en), 32'h0);
        tick; out("rr4_w0", 32'h100, 0);
        tick; out("rr4_w1", 32'h101, 1);
        tick; out("rr4_w2", 32'h102, 2);
        tick; out("rr4_w3", 32'h103, 3);
        chk("rr4_pend_done", 32'(bus.pending), 32'h0);
        tick;
        chk("rr4_idle", 32'(bus.internal_data_en), 32'h0);

        // rr_ptr back at 0: ch3+ch1 -> ch1 first
        put(3, 24'h000033); put(1, 24'h000011);
        tick;
        bus.in_data_en = '0;
        tick; out("rr2_w0", 32'h11, 1);
        tick; out("rr2_w1", 32'h33, 3);
        tick;
        chk("rr2_idle", 32'(bus.internal_data_en), 32'h0);

        // sign extension, 2-cycle latency, single-cycle pulse
        put(2, 24'h800000);
        tick;
        bus.in_data_en = '0;
        chk("sx_lat", 32'(bus.internal_data_en), 32'h0);
        tick; out("sx_neg", 32'hFF800000, 2);
        tick;
        chk("sx_pulse", 32'(bus.internal_data_en), 32'h0);
        chk("sx_hold",  bus.internal_data, 32'hFF800000);
        put(1, 24'h7FFFFF);
        tick;
        bus.in_data_en = '0;
        tick; out("sx_pos", 32'h007FFFFF, 1);
        tick;

        // backpressure with overwrite
        bus.out_ready = 1'b0;
        put(0, 24'h000011);
        tick;
        put(0, 24'h000022);
        tick;
        bus.in_data_en = '0;
        chk("bp_pend", 32'(bus.pending), 32'h1);
        chk("bp_ovr",  32'(bus.overrun), EXP_OVR0);
        chk("bp_en",   32'(bus.internal_data_en), 32'h0);
        tick;
        chk("bp_stall", 32'(bus.internal_data_en), 32'h0);
        bus.out_ready = 1'b1;
        tick; out("bp_word", 32'h22, 0);
        chk("bp_pend_clr", 32'(bus.pending), 32'h0);
        tick;
        chk("bp_single", 32'(bus.internal_data_en), 32'h0);
        chk("bp_ovr_sticky", 32'(bus.overrun), EXP_OVR0);
        bus.overrun_clr = 1'b1;
        tick;
        bus.overrun_clr = 1'b0;
        chk("bp_ovr_clr", 32'(bus.overrun), 32'h0);

        // capture in the grant cycle: old word out, new word kept, no overrun
        bus.out_ready = 1'b0;
        put(0, 24'h000005);
        tick;
        bus.out_ready = 1'b1;
        put(0, 24'h000006);
        tick;
        bus.in_data_en = '0;
        out("col_w0", 32'h5, 0);
        chk("col_pend", 32'(bus.pending), 32'h1);
        chk("col_ovr",  32'(bus.overrun), 32'h0);
        tick; out("col_w1", 32'h6, 0);
        chk("col_ovr2", 32'(bus.overrun), 32'h0);
        tick;

        // asynchronous reset mid-burst
        bus.out_ready = 1'b0;
        for (int k = 0; k < NUM_CH; k++) put(k, 24'h000A00 + 24'(k));
        tick;
        bus.in_data_en = '0;
        chk("mr_pend", 32'(bus.pending), 32'hF);
        rst = 1'b0;
        #1;
        chk("mr_pend0", 32'(bus.pending), 32'h0);
        chk("mr_data0", bus.internal_data, 32'h0);
        chk("mr_en0",   32'(bus.internal_data_en), 32'h0);
        chk("mr_ch0",   32'(bus.internal_ch), 32'h0);
        tick;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        chk("mr_discard", 32'(bus.internal_data_en), 32'h0);
        put(3, 24'h00000B); put(0, 24'h00000A);
        tick;
        bus.in_data_en = '0;
        tick; out("mr_first", 32'hA, 0);
        tick; out("mr_second", 32'hB, 3);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
